// File: rtl/oc8051_alu_pkg.sv
// Shared ALU types for the 8051 MUL sequencer: state encoding, operand byte, product record.
// Optional zero-operand shortcut lives in oc8051_mul_ctrl behind OC8051_MUL_FASTPATH_EN.
package oc8051_alu_pkg;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int WDOG_LIMIT_DEF = 8;

  typedef logic [7:0] byte_t;

  typedef struct packed {
    byte_t hi;
    byte_t lo;
    logic  ov;
  } mul_prod_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_WB    = 2'b11
  } mul_state_e;

endpackage

// File: rtl/oc8051_mul_ctrl_if.sv
// Bundle between decode, the iterative multiplier, writeback and the MUL sequencer.
// The slave modport is the sequencer's view; master is everything around it.
interface oc8051_mul_ctrl_if;
  import oc8051_alu_pkg::*;

  logic  req_valid;
  logic  req_ready;
  byte_t req_acc;
  byte_t req_b;
  logic  flush;
  logic  mul_en;
  byte_t mul_src1;
  byte_t mul_src2;
  logic  mul_valid;
  byte_t mul_hi;
  byte_t mul_lo;
  logic  mul_ov;
  logic  wb_valid;
  logic  wb_ready;
  byte_t wb_acc;
  byte_t wb_b;
  logic  wb_ov;
  logic  wb_cy;
  logic  err;

  modport slave (
    input  req_valid, req_acc, req_b, flush,
    input  mul_valid, mul_hi, mul_lo, mul_ov,
    input  wb_ready,
    output req_ready, mul_en, mul_src1, mul_src2,
    output wb_valid, wb_acc, wb_b, wb_ov, wb_cy, err
  );

  modport master (
    output req_valid, req_acc, req_b, flush,
    output mul_valid, mul_hi, mul_lo, mul_ov,
    output wb_ready,
    input  req_ready, mul_en, mul_src1, mul_src2,
    input  wb_valid, wb_acc, wb_b, wb_ov, wb_cy, err
  );

endinterface

// File: rtl/oc8051_mul_ctrl.sv
// MUL AB sequencer: latches operands, runs the 4-cycle multiplier, holds the writeback.
// Define OC8051_MUL_FASTPATH_EN to retire zero-operand multiplies without the multiplier.
module oc8051_mul_ctrl
  import oc8051_alu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
  input logic               clk,
  input logic               rst,
  oc8051_mul_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WDOG_LIMIT + 1);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_en_q, mul_en_d;
  byte_t            src1_q, src1_d;
  byte_t            src2_q, src2_d;
  mul_prod_t        prod_q, prod_d;
  logic             wb_valid_q, wb_valid_d;
  logic             err_q, err_d;

  logic fast_zero;
  logic last_iter;
  logic wdog_hit;

`ifdef OC8051_MUL_FASTPATH_EN
  assign fast_zero = (bus.req_acc == 8'h00) || (bus.req_b == 8'h00);
`else
  assign fast_zero = 1'b0;
`endif

  // Only the valid that lines up with our own count is trusted; it keeps us in step with the multiplier.
  assign last_iter = bus.mul_valid && (cnt_q == CNT_W'(MUL_CYCLES - 1));
  assign wdog_hit  = (cnt_q == CNT_W'(WDOG_LIMIT - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_en_d   = mul_en_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    prod_d     = prod_q;
    wb_valid_d = wb_valid_q;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          src1_d = bus.req_acc;
          src2_d = bus.req_b;
          cnt_d  = '0;
          if (fast_zero) begin
            prod_d     = '0;
            wb_valid_d = 1'b1;
            state_d    = ST_WB;
          end else begin
            mul_en_d = 1'b1;
            state_d  = ST_RUN;
          end
        end
      end

      ST_RUN, ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          mul_en_d = 1'b0;
          state_d  = ST_IDLE;
          if (state_q == ST_RUN && !bus.flush) begin
            prod_d     = '{hi: bus.mul_hi, lo: bus.mul_lo, ov: bus.mul_ov};
            wb_valid_d = 1'b1;
            state_d    = ST_WB;
          end
        end else if (wdog_hit) begin
          err_d    = 1'b1;
          mul_en_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (state_q == ST_RUN && bus.flush) begin
          // Keep the multiplier enabled so its internal counter wraps back to zero.
          state_d = ST_DRAIN;
        end
      end

      ST_WB: begin
        if (bus.flush || bus.wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mul_en_q   <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      prod_q     <= '0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mul_en_q   <= mul_en_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      prod_q     <= prod_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.mul_en    = mul_en_q;
  assign bus.mul_src1  = src1_q;
  assign bus.mul_src2  = src2_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_acc    = prod_q.lo;
  assign bus.wb_b      = prod_q.hi;
  assign bus.wb_ov     = prod_q.ov;
  assign bus.wb_cy     = 1'b0;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_oc8051_mul_ctrl.sv
// Directed bench for oc8051_mul_ctrl with a behavioural 4-cycle iterative multiplier.
// Expected latencies follow OC8051_MUL_FASTPATH_EN when the bench is built with it.
module tb_oc8051_mul_ctrl;

  logic clk;
  logic rst;
  logic stub_never;
  logic [1:0] m_cnt;
  logic [15:0] m_prod;

  int checks;
  int errors;

  oc8051_mul_ctrl_if bus();

  oc8051_mul_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: valid on the 4th enabled cycle, counter shares rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= 2'd0;
    else if (bus.mul_en) m_cnt <= m_cnt + 2'd1;
  end
  assign m_prod        = 16'(bus.mul_src1) * 16'(bus.mul_src2);
  assign bus.mul_hi    = m_prod[15:8];
  assign bus.mul_lo    = m_prod[7:0];
  assign bus.mul_ov    = (m_prod[15:8] != 8'h00);
  assign bus.mul_valid = bus.mul_en && (m_cnt == 2'd3) && !stub_never;

  typedef struct {
    logic [7:0] acc;
    logic [7:0] b;
    int         ready_wait;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       ov;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit zero;
    int lat;
    int en_cnt;
    int exp_lat;
    int exp_en;
    zero = (v.acc == 8'h00) || (v.b == 8'h00);
`ifdef OC8051_MUL_FASTPATH_EN
    exp_lat = zero ? 1 : 5;
    exp_en  = zero ? 0 : 4;
`else
    exp_lat = 5;
    exp_en  = 4;
`endif
    @(negedge clk);
    chk("req_ready_before", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_acc   = v.acc;
    bus.req_b     = v.b;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (exp_en != 0) begin
      chk("mul_src1", bus.mul_src1, v.acc);
      chk("mul_src2", bus.mul_src2, v.b);
    end
    lat = 1;
    en_cnt = 0;
    while (!bus.wb_valid && lat < 20) begin
      if (bus.mul_en) en_cnt++;
      @(negedge clk);
      lat++;
    end
    chk("wb_latency", lat, exp_lat);
    chk("mul_en_cycles", en_cnt, exp_en);
    for (int w = 0; w <= v.ready_wait; w++) begin
      chk("wb_valid_hold", bus.wb_valid, 1);
      chk("wb_acc", bus.wb_acc, v.lo);
      chk("wb_b", bus.wb_b, v.hi);
      chk("wb_ov", bus.wb_ov, v.ov);
      chk("wb_cy", bus.wb_cy, 0);
      chk("req_ready_busy", bus.req_ready, 0);
      chk("mul_en_in_wb", bus.mul_en, 0);
      if (w == v.ready_wait) bus.wb_ready = 1'b1;
      @(negedge clk);
    end
    bus.wb_ready = 1'b0;
    chk("wb_valid_drop", bus.wb_valid, 0);
    chk("req_ready_after", bus.req_ready, 1);
    $display("txn %02h x %02h: lat=%0d en=%0d wb_acc=%02h wb_b=%02h ov=%0b",
             v.acc, v.b, lat, en_cnt, bus.wb_acc, bus.wb_b, bus.wb_ov);
  endtask

  initial begin
    int en_cnt;
    int wb_seen;
    int err_at;
    vec_t v;
    checks = 0;
    errors = 0;
    stub_never    = 1'b0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_acc   = 8'h00;
    bus.req_b     = 8'h00;
    bus.flush     = 1'b0;
    bus.wb_ready  = 1'b0;

    vecs[0] = '{acc: 8'h50, b: 8'hA0, ready_wait: 0, lo: 8'h00, hi: 8'h32, ov: 1'b1};
    vecs[1] = '{acc: 8'h07, b: 8'h09, ready_wait: 3, lo: 8'h3F, hi: 8'h00, ov: 1'b0};
    vecs[2] = '{acc: 8'hFF, b: 8'hFF, ready_wait: 0, lo: 8'h01, hi: 8'hFE, ov: 1'b1};
    vecs[3] = '{acc: 8'h10, b: 8'h10, ready_wait: 1, lo: 8'h00, hi: 8'h01, ov: 1'b1};
    vecs[4] = '{acc: 8'h00, b: 8'h7F, ready_wait: 0, lo: 8'h00, hi: 8'h00, ov: 1'b0};
    vecs[5] = '{acc: 8'h0F, b: 8'h11, ready_wait: 2, lo: 8'hFF, hi: 8'h00, ov: 1'b0};
    vecs[6] = '{acc: 8'h80, b: 8'h02, ready_wait: 0, lo: 8'h00, hi: 8'h01, ov: 1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_mul_en", bus.mul_en, 0);
    chk("rst_src", {bus.mul_src1, bus.mul_src2}, 0);
    chk("rst_wb", {bus.wb_valid, bus.wb_acc, bus.wb_b, bus.wb_ov, bus.wb_cy}, 0);
    chk("rst_err", bus.err, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Flush on the second RUN cycle: multiplier must still see all four enables.
    bus.req_valid = 1'b1;
    bus.req_acc   = 8'h50;
    bus.req_b     = 8'hA0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    en_cnt = 0;
    wb_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      if (bus.mul_en) en_cnt++;
      if (bus.wb_valid) wb_seen++;
      bus.flush = (i == 2);
      @(negedge clk);
    end
    chk("flush_run_en_cycles", en_cnt, 4);
    chk("flush_run_no_wb", wb_seen, 0);
    chk("flush_run_ready", bus.req_ready, 1);
    $display("txn flush-in-RUN: en=%0d wb_seen=%0d", en_cnt, wb_seen);
    v = '{acc: 8'hFF, b: 8'hFF, ready_wait: 0, lo: 8'h01, hi: 8'hFE, ov: 1'b1};
    run_vec(v);

    // Flush while the result is waiting in WB.
    bus.req_valid = 1'b1;
    bus.req_acc   = 8'h07;
    bus.req_b     = 8'h09;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.wb_valid; i++) @(negedge clk);
    chk("flush_wb_reached", bus.wb_valid, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_wb_drop", bus.wb_valid, 0);
    chk("flush_wb_ready", bus.req_ready, 1);
    $display("txn flush-in-WB: wb_valid=%0b req_ready=%0b", bus.wb_valid, bus.req_ready);

    // Flush in IDLE beats a simultaneous request.
    bus.req_valid = 1'b1;
    bus.req_acc   = 8'h03;
    bus.req_b     = 8'h04;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    chk("flush_idle_no_en", bus.mul_en, 0);
    chk("flush_idle_no_wb", bus.wb_valid, 0);
    chk("flush_idle_ready", bus.req_ready, 1);
    $display("txn flush-in-IDLE: mul_en=%0b req_ready=%0b", bus.mul_en, bus.req_ready);

    // Watchdog: multiplier never reports valid.
    stub_never    = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_acc   = 8'h11;
    bus.req_b     = 8'h22;
    @(negedge clk);
    bus.req_valid = 1'b0;
    en_cnt = 0;
    err_at = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.err) begin
        err_at = i;
        break;
      end
      if (bus.mul_en) en_cnt++;
      @(negedge clk);
    end
    chk("wdog_err_cycle", err_at, 9);
    chk("wdog_en_cycles", en_cnt, 8);
    chk("wdog_mul_en_off", bus.mul_en, 0);
    chk("wdog_ready", bus.req_ready, 1);
    chk("wdog_no_wb", bus.wb_valid, 0);
    @(negedge clk);
    chk("wdog_err_pulse", bus.err, 0);
    stub_never = 1'b0;
    $display("txn watchdog: err_at=%0d en=%0d", err_at, en_cnt);

    // Asynchronous reset in the middle of RUN.
    bus.req_valid = 1'b1;
    bus.req_acc   = 8'h50;
    bus.req_b     = 8'hA0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_running", bus.mul_en, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", bus.req_ready, 1);
    chk("midrst_mul_en", bus.mul_en, 0);
    chk("midrst_src", {bus.mul_src1, bus.mul_src2}, 0);
    chk("midrst_wb", {bus.wb_valid, bus.wb_acc, bus.wb_b, bus.wb_ov}, 0);
    chk("midrst_err", bus.err, 0);
    rst = 1'b0;
    $display("txn reset-mid-RUN: req_ready=%0b mul_en=%0b", bus.req_ready, bus.mul_en);
    v = '{acc: 8'h02, b: 8'h03, ready_wait: 0, lo: 8'h06, hi: 8'h00, ov: 1'b0};
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
